spiram_arbiter: RTL
===================

# spiram_arbiter

Two-port arbiter and sequencer in front of the memory-mapped SPI RAM controller. It shares that controller between a CPU port (port 0) and a DMA/peripheral port (port 1). Word writes with a byte mask are split into one byte-write transaction per enabled lane, because the controller writes a single byte per command. The block drives the controller's read/write strobes and tracks its busy flags. It returns read data or write completion to the winning port with a one-cycle ack.

## Interface
Parameters:
- TIMEOUT, 255: cycles a strobe may stay asserted without the matching busy rising before the access is aborted.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- p0_req / p1_req  in  1  request; held high until the matching ack.
- p0_we / p1_we  in  1  1 = write, 0 = read; stable while req is high.
- p0_addr / p1_addr  in  18  word address; stable while req is high.
- p0_wdata / p1_wdata  in  32  write data, lane i = bits [8i+7:8i].
- p0_wmask / p1_wmask  in  4  byte-lane enables for writes; ignored on reads.
- p0_rdata / p1_rdata  out  32  read data; valid in the ack cycle and held until the next ack on that port.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when an access is aborted by timeout.
- spi_rd / spi_wr  out  1  strobes to the controller.
- spi_word_address  out  20  byte address to the controller: {addr, lane[1:0]}.
- spi_wdata  out  32  bits [7:0] carry the lane byte; [31:8] driven 0.
- spi_rdata  in  32  controller read data, already byte-swizzled.
- spi_rbusy / spi_wbusy  in  1  controller busy flags.

## Operation
- Reset values: all acks, err, spi_rd and spi_wr are 0; spi_word_address, spi_wdata and both rdata outputs are 0; state is IDLE; round-robin pointer points at port 0.
- States:
  - IDLE: choose a grant among requesting ports. Latch we, addr, wdata and wmask of the winner.
    - Read: go to ISSUE with lane 0.
    - Write with wmask != 0: go to ISSUE with the lowest set lane.
    - Write with wmask == 0: go straight to RESP, with no controller access.
  - ISSUE: spi_rd or spi_wr held at 1.
    - Go to WAIT_DONE on the edge where the matching busy is sampled 1; the strobe clears on that same edge.
    - If TIMEOUT cycles elapse in ISSUE first: clear the strobe, pulse err, go to RESP. A read abort returns 32'hFFFF_FFFF.
  - WAIT_DONE: when the matching busy is sampled 0:
    - Write with higher enabled lanes remaining: go to ISSUE with the next set lane.
    - Otherwise: capture spi_rdata (reads only), go to RESP.
  - RESP: pulse ack on the granted port; update that port's rdata on reads; go to IDLE.
- Lanes are issued in ascending order; disabled lanes are skipped, never issued.
- Reads are always one controller transaction at lane 0 (address {addr, 2'b00}).
- A port's new request is never accepted before its previous ack has completed; req is sampled again in IDLE.
- Asynchronous reset mid-transaction returns to IDLE with strobes low. The in-flight request is dropped without an ack; a requester still holding req is re-arbitrated after reset.

## Timing
- Req sampled at IDLE edge E: the strobe is high in the cycle after E.
- Minimum read latency from grant edge to ack: 1 (ISSUE) + controller busy time + 1 (WAIT_DONE exit) + 1 (RESP).
- Writes take one ISSUE/WAIT_DONE pair per enabled lane. Consecutive lanes are never back-to-back: there is at least one idle strobe cycle between lanes.
- Ack is exactly one cycle wide, in the cycle after the RESP transition. At least one IDLE cycle separates successive grants.
- Timeout counter is 8 bits wide (sized to TIMEOUT), cleared on each entry to ISSUE, and saturates.

## Configuration
- SPIRAM_ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, the port not granted last wins; the pointer updates at each grant.
- Not defined: fixed priority, port 0 always wins a simultaneous request; the pointer logic is removed.

## Test plan
- Port 0 read, addr 18'h00010, controller busy high 40 cycles, spi_rdata 32'hDEADBEEF -> one spi_rd with spi_word_address 20'h00040; p0_ack pulses once; p0_rdata = 32'hDEADBEEF.
- Port 1 write, wmask 4'b1010, wdata 32'h11223344 -> two spi_wr transactions: address {addr,2'd1} with byte 8'h33, then {addr,2'd3} with byte 8'h11; single p1_ack after the second.
- Write with wmask 4'b0000 -> no spi strobe; ack within 3 cycles of req.
- Both req high continuously -> with SPIRAM_ARB_RR_EN, acks alternate 0,1,0,1; without it, port 0 wins every grant while it requests.
- Busy never rises -> after 255 cycles strobe drops, err pulses once, read ack returns 32'hFFFF_FFFF.
- Reset asserted during WAIT_DONE -> all outputs return to reset values immediately; no ack for the dropped request; re-arbitration after reset release.

Source files
------------

// File: rtl/spiram_arbiter.sv
// spiram_arbiter
// ---------------------------------------------------------------------------
// Shares one memory-mapped SPI RAM controller between a CPU port (port 0) and
// a DMA/peripheral port (port 1). The controller writes one byte per command,
// so masked word writes are split into one byte write per enabled lane,
// issued in ascending lane order. Reads are a single lane-0 transaction.
// Completion is returned to the granted port as a one-cycle ack.
//
// Configuration macro: SPIRAM_ARB_RR_EN
//   defined   -> round-robin arbitration between the two ports
//   undefined -> fixed priority, port 0 wins simultaneous requests
//
// Ports:
//   clk, reset              clock and asynchronous active-low reset
//   pN_req/we/addr/wdata/wmask  request side of port N (held until ack)
//   pN_rdata, pN_ack        read data (held between acks) and ack pulse
//   err                     one-cycle pulse when an access times out
//   spi_rd, spi_wr          strobes to the controller
//   spi_word_address        byte address {word addr, lane}
//   spi_wdata               lane byte in [7:0], upper bits zero
//   spi_rdata               controller read data
//   spi_rbusy, spi_wbusy    controller busy flags
// ---------------------------------------------------------------------------
module spiram_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [17:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wmask,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [17:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wmask,
  output logic [31:0] p0_rdata,
  output logic [31:0] p1_rdata,
  output logic        p0_ack,
  output logic        p1_ack,
  output logic        err,
  output logic        spi_rd,
  output logic        spi_wr,
  output logic [19:0] spi_word_address,
  output logic [31:0] spi_wdata,
  input  logic [31:0] spi_rdata,
  input  logic        spi_rbusy,
  input  logic        spi_wbusy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [17:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [1:0]  lane_q, lane_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        p0_ack_q, p0_ack_d, p1_ack_q, p1_ack_d;
  logic        err_q, err_d;
  logic        spi_rd_q, spi_rd_d, spi_wr_q, spi_wr_d;
  logic [19:0] spi_addr_q, spi_addr_d;
  logic [31:0] spi_wdata_q, spi_wdata_d;
  logic [31:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;
`ifdef SPIRAM_ARB_RR_EN
  logic        prio_q, prio_d;
`endif

  logic        grantValid, grantPort;
  logic        winWe;
  logic [17:0] winAddr;
  logic [31:0] winWdata;
  logic [3:0]  winMask;
  logic        busySel, timeoutHit, moreLanes;
  logic [3:0]  remainMask;

  // Lowest enabled lane of a mask (mask assumed non-zero by callers).
  function automatic logic [1:0] lowestLane(input logic [3:0] m);
    logic [1:0] l;
    l = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) l = 2'(i);
    end
    return l;
  endfunction

  // Arbitration. No grant is made while an ack is on the wire, so a port
  // holding req through its ack is seen as a fresh request one cycle later.
  always_comb begin
    grantValid = (p0_req | p1_req) & ~(p0_ack_q | p1_ack_q);
`ifdef SPIRAM_ARB_RR_EN
    grantPort  = (p0_req & p1_req) ? prio_q : p1_req;
`else
    grantPort  = ~p0_req;
`endif
    winWe    = grantPort ? p1_we    : p0_we;
    winAddr  = grantPort ? p1_addr  : p0_addr;
    winWdata = grantPort ? p1_wdata : p0_wdata;
    winMask  = grantPort ? p1_wmask : p0_wmask;
  end

  always_comb begin
    busySel    = we_q ? spi_wbusy : spi_rbusy;
    timeoutHit = (tcnt_q == TW'(TIMEOUT - 1));
    remainMask = wmask_q & (4'b1110 << lane_q);
    moreLanes  = we_q & (|remainMask);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grantValid) begin
          if (!winWe || (winMask != 4'd0)) state_d = ISSUE;
          else                             state_d = RESP;
        end
      end
      ISSUE: begin
        if (busySel)         state_d = WAIT_DONE;
        else if (timeoutHit) state_d = RESP;
      end
      WAIT_DONE: begin
        if (!busySel) state_d = moreLanes ? ISSUE : RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values. Strobes, address and data are
  // registered so the controller sees clean signals one cycle after the
  // decision edge.
  always_comb begin
    grant_d     = grant_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    lane_d      = lane_q;
    tcnt_d      = tcnt_q;
    rbuf_d      = rbuf_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    err_d       = 1'b0;
    spi_rd_d    = spi_rd_q;
    spi_wr_d    = spi_wr_q;
    spi_addr_d  = spi_addr_q;
    spi_wdata_d = spi_wdata_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
`ifdef SPIRAM_ARB_RR_EN
    prio_d      = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (grantValid) begin
          grant_d = grantPort;
          we_d    = winWe;
          addr_d  = winAddr;
          wdata_d = winWdata;
          wmask_d = winMask;
          lane_d  = winWe ? lowestLane(winMask) : 2'd0;
`ifdef SPIRAM_ARB_RR_EN
          prio_d  = ~grantPort;
`endif
          if (!winWe || (winMask != 4'd0)) begin
            spi_rd_d    = ~winWe;
            spi_wr_d    = winWe;
            spi_addr_d  = {winAddr, lane_d};
            spi_wdata_d = {24'd0, winWdata[{lane_d, 3'b000} +: 8]};
            tcnt_d      = '0;
          end
        end
      end
      ISSUE: begin
        if (busySel) begin
          spi_rd_d = 1'b0;
          spi_wr_d = 1'b0;
        end else if (timeoutHit) begin
          spi_rd_d = 1'b0;
          spi_wr_d = 1'b0;
          err_d    = 1'b1;
          rbuf_d   = 32'hFFFF_FFFF;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!busySel) begin
          if (moreLanes) begin
            lane_d      = lowestLane(remainMask);
            spi_wr_d    = 1'b1;
            spi_addr_d  = {addr_q, lane_d};
            spi_wdata_d = {24'd0, wdata_q[{lane_d, 3'b000} +: 8]};
            tcnt_d      = '0;
          end else if (!we_q) begin
            rbuf_d = spi_rdata;
          end
        end
      end
      RESP: begin
        if (grant_q) begin
          p1_ack_d = 1'b1;
          if (!we_q) p1_rdata_d = rbuf_q;
        end else begin
          p0_ack_d = 1'b1;
          if (!we_q) p0_rdata_d = rbuf_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      lane_q      <= '0;
      tcnt_q      <= '0;
      rbuf_q      <= '0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      err_q       <= 1'b0;
      spi_rd_q    <= 1'b0;
      spi_wr_q    <= 1'b0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
`ifdef SPIRAM_ARB_RR_EN
      prio_q      <= 1'b0;
`endif
    end else begin
      grant_q     <= grant_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      lane_q      <= lane_d;
      tcnt_q      <= tcnt_d;
      rbuf_q      <= rbuf_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      err_q       <= err_d;
      spi_rd_q    <= spi_rd_d;
      spi_wr_q    <= spi_wr_d;
      spi_addr_q  <= spi_addr_d;
      spi_wdata_q <= spi_wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
`ifdef SPIRAM_ARB_RR_EN
      prio_q      <= prio_d;
`endif
    end
  end

  assign p0_ack           = p0_ack_q;
  assign p1_ack           = p1_ack_q;
  assign err              = err_q;
  assign spi_rd           = spi_rd_q;
  assign spi_wr           = spi_wr_q;
  assign spi_word_address = spi_addr_q;
  assign spi_wdata        = spi_wdata_q;
  assign p0_rdata         = p0_rdata_q;
  assign p1_rdata         = p1_rdata_q;

endmodule
